// File: rtl/axilregs_pkg.sv
// Shared definitions for the AXI4-lite register bank.
package axilregs_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_e;

endpackage

// File: rtl/axilregs_if.sv
// AXI4-lite slave bus bundle; the master modport is the bus driver side.
interface axilregs_if #(
  parameter int DW = 64,
  parameter int AW = 8
) ();

  logic            S_AXIL_AWVALID;
  logic            S_AXIL_AWREADY;
  logic [AW-1:0]   S_AXIL_AWADDR;
  logic [2:0]      S_AXIL_AWPROT;
  logic            S_AXIL_WVALID;
  logic            S_AXIL_WREADY;
  logic [DW-1:0]   S_AXIL_WDATA;
  logic [DW/8-1:0] S_AXIL_WSTRB;
  logic            S_AXIL_BVALID;
  logic            S_AXIL_BREADY;
  logic [1:0]      S_AXIL_BRESP;
  logic            S_AXIL_ARVALID;
  logic            S_AXIL_ARREADY;
  logic [AW-1:0]   S_AXIL_ARADDR;
  logic [2:0]      S_AXIL_ARPROT;
  logic            S_AXIL_RVALID;
  logic            S_AXIL_RREADY;
  logic [DW-1:0]   S_AXIL_RDATA;
  logic [1:0]      S_AXIL_RRESP;

  modport master (
    output S_AXIL_AWVALID, S_AXIL_AWADDR, S_AXIL_AWPROT,
    output S_AXIL_WVALID, S_AXIL_WDATA, S_AXIL_WSTRB,
    output S_AXIL_BREADY,
    output S_AXIL_ARVALID, S_AXIL_ARADDR, S_AXIL_ARPROT,
    output S_AXIL_RREADY,
    input  S_AXIL_AWREADY, S_AXIL_WREADY, S_AXIL_BVALID, S_AXIL_BRESP,
    input  S_AXIL_ARREADY, S_AXIL_RVALID, S_AXIL_RDATA, S_AXIL_RRESP
  );

  modport slave (
    input  S_AXIL_AWVALID, S_AXIL_AWADDR, S_AXIL_AWPROT,
    input  S_AXIL_WVALID, S_AXIL_WDATA, S_AXIL_WSTRB,
    input  S_AXIL_BREADY,
    input  S_AXIL_ARVALID, S_AXIL_ARADDR, S_AXIL_ARPROT,
    input  S_AXIL_RREADY,
    output S_AXIL_AWREADY, S_AXIL_WREADY, S_AXIL_BVALID, S_AXIL_BRESP,
    output S_AXIL_ARREADY, S_AXIL_RVALID, S_AXIL_RDATA, S_AXIL_RRESP
  );

endinterface

// File: rtl/axilregs_skidbuffer.sv
// One-deep skid buffer with combinational pass-through (no output register).
module axilregs_skidbuffer #(
  parameter int WIDTH        = 8,
  parameter bit OPT_LOWPOWER = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic             held;
  logic [WIDTH-1:0] held_data;

  always_ff @(posedge clk) begin
    if (rst)
      held <= 1'b0;
    else if (s_valid && !held && !m_ready)
      held <= 1'b1;
    else if (m_ready)
      held <= 1'b0;
  end

  // Capture whatever is on the input while empty; it is only used once held.
  always_ff @(posedge clk) begin
    if (OPT_LOWPOWER && rst)
      held_data <= '0;
    else if (!held)
      held_data <= (OPT_LOWPOWER && !s_valid) ? '0 : s_data;
  end

  assign s_ready = !held;

  always_comb begin
    m_valid = s_valid || held;
    m_data  = held ? held_data : s_data;
    if (OPT_LOWPOWER && !m_valid)
      m_data = '0;
  end

endmodule

// File: rtl/axilregs.sv
// Wide AXI4-lite register bank: byte-strobed writes, registered reads.
module axilregs
  import axilregs_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = 64,
  parameter int C_AXI_ADDR_WIDTH = 8,
  parameter bit OPT_LOWPOWER     = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  axilregs_if.slave  s_axil
);

  localparam int          DW      = C_AXI_DATA_WIDTH;
  localparam int          SW      = DW / 8;
  localparam int          ADDRLSB = $clog2(SW);
  localparam int          IW      = C_AXI_ADDR_WIDTH - ADDRLSB;
  localparam int unsigned NREGS   = 1 << IW;

  logic          aw_valid, w_valid, ar_valid;
  logic [IW-1:0] aw_idx, ar_idx;
  logic [DW-1:0] w_data;
  logic [SW-1:0] w_strb;
  logic          wr, rd;
  logic          bvalid, rvalid;
  logic [DW-1:0] rdata;
  logic [DW-1:0] regs [NREGS];

  axilregs_skidbuffer #(.WIDTH(IW), .OPT_LOWPOWER(1'b0)) u_awskd (
    .clk(i_clk), .rst(i_reset),
    .s_valid(s_axil.S_AXIL_AWVALID), .s_ready(s_axil.S_AXIL_AWREADY),
    .s_data(s_axil.S_AXIL_AWADDR[C_AXI_ADDR_WIDTH-1:ADDRLSB]),
    .m_valid(aw_valid), .m_ready(wr), .m_data(aw_idx)
  );

  axilregs_skidbuffer #(.WIDTH(DW + SW), .OPT_LOWPOWER(OPT_LOWPOWER)) u_wskd (
    .clk(i_clk), .rst(i_reset),
    .s_valid(s_axil.S_AXIL_WVALID), .s_ready(s_axil.S_AXIL_WREADY),
    .s_data({s_axil.S_AXIL_WSTRB, s_axil.S_AXIL_WDATA}),
    .m_valid(w_valid), .m_ready(wr), .m_data({w_strb, w_data})
  );

  axilregs_skidbuffer #(.WIDTH(IW), .OPT_LOWPOWER(1'b0)) u_arskd (
    .clk(i_clk), .rst(i_reset),
    .s_valid(s_axil.S_AXIL_ARVALID), .s_ready(s_axil.S_AXIL_ARREADY),
    .s_data(s_axil.S_AXIL_ARADDR[C_AXI_ADDR_WIDTH-1:ADDRLSB]),
    .m_valid(ar_valid), .m_ready(rd), .m_data(ar_idx)
  );

  assign wr = aw_valid && w_valid && (!bvalid || s_axil.S_AXIL_BREADY);
  assign rd = ar_valid && (!rvalid || s_axil.S_AXIL_RREADY);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned r = 0; r < NREGS; r++)
        regs[r] <= '0;
    end else if (wr) begin
      for (int unsigned b = 0; b < SW; b++)
        if (w_strb[b])
          regs[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      bvalid <= 1'b0;
    else if (wr)
      bvalid <= 1'b1;
    else if (s_axil.S_AXIL_BREADY)
      bvalid <= 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (rd) begin
      rvalid <= 1'b1;
      rdata  <= regs[ar_idx];
    end else if (s_axil.S_AXIL_RREADY) begin
      rvalid <= 1'b0;
      if (OPT_LOWPOWER)
        rdata <= '0;
    end
  end

  assign s_axil.S_AXIL_BVALID = bvalid;
  assign s_axil.S_AXIL_BRESP  = RESP_OKAY;
  assign s_axil.S_AXIL_RVALID = rvalid;
  assign s_axil.S_AXIL_RDATA  = rdata;
  assign s_axil.S_AXIL_RRESP  = RESP_OKAY;

  logic unused;
  assign unused = &{1'b0, s_axil.S_AXIL_AWPROT, s_axil.S_AXIL_ARPROT,
                    s_axil.S_AXIL_AWADDR[ADDRLSB-1:0], s_axil.S_AXIL_ARADDR[ADDRLSB-1:0]};

endmodule

// File: tb/tb_axilregs.sv
// Self-checking bench for axilregs: directed scenarios plus randomized traffic.
module tb_axilregs;
  import axilregs_pkg::*;

  localparam int DW = 64;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axilregs_if #(.DW(DW), .AW(AW)) ifc ();

  axilregs #(.C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW), .OPT_LOWPOWER(1'b1)) dut (
    .i_clk(clk), .i_reset(rst), .s_axil(ifc)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] mem [32];
  logic [7:0]  rw_a [64];
  logic [63:0] rw_d [64];
  logic [7:0]  rw_s [64];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_write(input logic [7:0] a, input logic [63:0] d, input logic [7:0] s);
    for (int b = 0; b < 8; b++)
      if (s[b]) mem[a[7:3]][8*b +: 8] = d[8*b +: 8];
  endtask

  // Handshake-level protocol monitor: stalled responses must hold.
  logic p_bv = 1'b0, p_br = 1'b0, p_rv = 1'b0, p_rr = 1'b0, p_rst = 1'b1;
  logic [63:0] p_rd = '0;
  always @(negedge clk) begin
    if (!p_rst && p_bv && !p_br) check("b_hold", ifc.S_AXIL_BVALID, 1);
    if (!p_rst && p_rv && !p_rr) begin
      check("r_hold", ifc.S_AXIL_RVALID, 1);
      check("r_hold_data", ifc.S_AXIL_RDATA, p_rd);
    end
    p_bv  <= ifc.S_AXIL_BVALID;
    p_br  <= ifc.S_AXIL_BREADY;
    p_rv  <= ifc.S_AXIL_RVALID;
    p_rr  <= ifc.S_AXIL_RREADY;
    p_rd  <= ifc.S_AXIL_RDATA;
    p_rst <= rst;
  end

  task automatic wr(input logic [7:0] a, input logic [63:0] d, input logic [7:0] s);
    logic aw_done = 1'b0, w_done = 1'b0;
    int n = 0;
    ifc.S_AXIL_AWVALID = 1'b1; ifc.S_AXIL_AWADDR = a;
    ifc.S_AXIL_WVALID  = 1'b1; ifc.S_AXIL_WDATA = d; ifc.S_AXIL_WSTRB = s;
    ifc.S_AXIL_BREADY  = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      @(negedge clk);
      if (ifc.S_AXIL_AWVALID && ifc.S_AXIL_AWREADY) aw_done = 1'b1;
      if (ifc.S_AXIL_WVALID && ifc.S_AXIL_WREADY) w_done = 1'b1;
      @(posedge clk); #1;
      if (aw_done) ifc.S_AXIL_AWVALID = 1'b0;
      if (w_done)  ifc.S_AXIL_WVALID = 1'b0;
      n++;
    end
    ifc.S_AXIL_AWVALID = 1'b0; ifc.S_AXIL_WVALID = 1'b0;
    check("wr_accept", {aw_done, w_done}, 2'b11);
    @(negedge clk);
    check("wr_bvalid", ifc.S_AXIL_BVALID, 1);
    check("wr_bresp", ifc.S_AXIL_BRESP, RESP_OKAY);
    model_write(a, d, s);
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [7:0] a, input string tag);
    logic done = 1'b0;
    int n = 0;
    ifc.S_AXIL_ARVALID = 1'b1; ifc.S_AXIL_ARADDR = a; ifc.S_AXIL_RREADY = 1'b1;
    while (!done && n < 20) begin
      @(negedge clk); done = ifc.S_AXIL_ARREADY;
      @(posedge clk); #1; n++;
    end
    ifc.S_AXIL_ARVALID = 1'b0;
    check({tag, "_accept"}, done, 1);
    @(negedge clk);
    check({tag, "_rvalid"}, ifc.S_AXIL_RVALID, 1);
    check({tag, "_rresp"}, ifc.S_AXIL_RRESP, RESP_OKAY);
    check(tag, ifc.S_AXIL_RDATA, mem[a[7:3]]);
    @(posedge clk); #1;
  endtask

  task automatic bp_test();
    logic [63:0] wdat [3];
    int bcnt = 0, rcnt = 0;
    for (int i = 0; i < 3; i++) wdat[i] = {$urandom, $urandom};
    ifc.S_AXIL_BREADY = 1'b0; ifc.S_AXIL_RREADY = 1'b0;
    fork
      begin : aw_drv
        logic acc;
        for (int i = 0; i < 3; i++) begin
          int n = 0;
          ifc.S_AXIL_AWVALID = 1'b1; ifc.S_AXIL_AWADDR = 8'(8'h28 + 8*i);
          do begin
            @(negedge clk); acc = ifc.S_AXIL_AWREADY; @(posedge clk); #1; n++;
          end while (!acc && n < 60);
          if (!acc) check("bp_aw_timeout", 0, 1);
        end
        ifc.S_AXIL_AWVALID = 1'b0;
      end
      begin : w_drv
        logic acc;
        for (int i = 0; i < 3; i++) begin
          int n = 0;
          ifc.S_AXIL_WVALID = 1'b1; ifc.S_AXIL_WDATA = wdat[i]; ifc.S_AXIL_WSTRB = 8'hFF;
          do begin
            @(negedge clk); acc = ifc.S_AXIL_WREADY; @(posedge clk); #1; n++;
          end while (!acc && n < 60);
          if (!acc) check("bp_w_timeout", 0, 1);
        end
        ifc.S_AXIL_WVALID = 1'b0;
      end
      begin : ar_drv
        logic acc;
        for (int i = 0; i < 3; i++) begin
          int n = 0;
          ifc.S_AXIL_ARVALID = 1'b1; ifc.S_AXIL_ARADDR = 8'(8'h08 + 8*i);
          do begin
            @(negedge clk); acc = ifc.S_AXIL_ARREADY; @(posedge clk); #1; n++;
          end while (!acc && n < 60);
          if (!acc) check("bp_ar_timeout", 0, 1);
        end
        ifc.S_AXIL_ARVALID = 1'b0;
      end
      begin : ctl
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("bp_awready_low", ifc.S_AXIL_AWREADY, 0);
        check("bp_wready_low", ifc.S_AXIL_WREADY, 0);
        check("bp_arready_low", ifc.S_AXIL_ARREADY, 0);
        check("bp_bvalid", ifc.S_AXIL_BVALID, 1);
        check("bp_rvalid", ifc.S_AXIL_RVALID, 1);
        @(posedge clk); #1;
        ifc.S_AXIL_BREADY = 1'b1; ifc.S_AXIL_RREADY = 1'b1;
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (ifc.S_AXIL_BVALID && ifc.S_AXIL_BREADY) bcnt++;
          if (ifc.S_AXIL_RVALID && ifc.S_AXIL_RREADY) begin
            check("bp_rdata", ifc.S_AXIL_RDATA, mem[rcnt % 32 + 1]);
            rcnt++;
          end
          @(posedge clk); #1;
        end
      end
    join
    check("bp_bcount", bcnt, 3);
    check("bp_rcount", rcnt, 3);
    for (int i = 0; i < 3; i++) model_write(8'(8'h28 + 8*i), wdat[i], 8'hFF);
  endtask

  task automatic rnd_writes(input int nw);
    int bcnt = 0;
    for (int i = 0; i < nw; i++) begin
      rw_a[i] = 8'($urandom_range(0, 255));
      rw_d[i] = {$urandom, $urandom};
      rw_s[i] = 8'($urandom_range(0, 255));
      model_write(rw_a[i], rw_d[i], rw_s[i]);
    end
    fork
      begin : aw_drv
        logic acc;
        for (int i = 0; i < nw; i++) begin
          int n = 0;
          ifc.S_AXIL_AWVALID = 1'b0;
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          ifc.S_AXIL_AWVALID = 1'b1; ifc.S_AXIL_AWADDR = rw_a[i];
          do begin
            @(negedge clk); acc = ifc.S_AXIL_AWREADY; @(posedge clk); #1; n++;
          end while (!acc && n < 200);
          if (!acc) check("rnd_aw_timeout", 0, 1);
        end
        ifc.S_AXIL_AWVALID = 1'b0;
      end
      begin : w_drv
        logic acc;
        for (int i = 0; i < nw; i++) begin
          int n = 0;
          ifc.S_AXIL_WVALID = 1'b0;
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          ifc.S_AXIL_WVALID = 1'b1; ifc.S_AXIL_WDATA = rw_d[i]; ifc.S_AXIL_WSTRB = rw_s[i];
          do begin
            @(negedge clk); acc = ifc.S_AXIL_WREADY; @(posedge clk); #1; n++;
          end while (!acc && n < 200);
          if (!acc) check("rnd_w_timeout", 0, 1);
        end
        ifc.S_AXIL_WVALID = 1'b0;
      end
      begin : b_cons
        int n = 0;
        while (bcnt < nw && n < 3000) begin
          ifc.S_AXIL_BREADY = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (ifc.S_AXIL_BVALID && ifc.S_AXIL_BREADY) bcnt++;
          @(posedge clk); #1; n++;
        end
        ifc.S_AXIL_BREADY = 1'b1;
      end
    join
    @(negedge clk);
    check("rnd_bcount", bcnt, nw);
    check("rnd_b_drained", ifc.S_AXIL_BVALID, 0);
    @(posedge clk); #1;
  endtask

  task automatic rnd_reads(input int nr);
    logic [63:0] expq [$];
    int rcnt = 0;
    fork
      begin : ar_drv
        logic acc;
        for (int i = 0; i < nr; i++) begin
          int n = 0;
          ifc.S_AXIL_ARVALID = 1'b0;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          ifc.S_AXIL_ARVALID = 1'b1; ifc.S_AXIL_ARADDR = 8'($urandom_range(0, 255));
          do begin
            @(negedge clk); acc = ifc.S_AXIL_ARREADY;
            if (acc) expq.push_back(mem[ifc.S_AXIL_ARADDR[7:3]]);
            @(posedge clk); #1; n++;
          end while (!acc && n < 200);
          if (!acc) check("rnd_ar_timeout", 0, 1);
        end
        ifc.S_AXIL_ARVALID = 1'b0;
      end
      begin : r_cons
        int n = 0;
        while (rcnt < nr && n < 3000) begin
          ifc.S_AXIL_RREADY = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (ifc.S_AXIL_RVALID && ifc.S_AXIL_RREADY) begin
            if (expq.size() == 0) check("rnd_r_extra", 1, 0);
            else check("rnd_rdata", ifc.S_AXIL_RDATA, expq.pop_front());
            rcnt++;
          end
          @(posedge clk); #1; n++;
        end
        ifc.S_AXIL_RREADY = 1'b1;
      end
    join
    check("rnd_rcount", rcnt, nr);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] a9;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    ifc.S_AXIL_AWVALID = 1'b0; ifc.S_AXIL_AWADDR = '0; ifc.S_AXIL_AWPROT = '0;
    ifc.S_AXIL_WVALID  = 1'b0; ifc.S_AXIL_WDATA  = '0; ifc.S_AXIL_WSTRB  = '0;
    ifc.S_AXIL_BREADY  = 1'b1;
    ifc.S_AXIL_ARVALID = 1'b0; ifc.S_AXIL_ARADDR = '0; ifc.S_AXIL_ARPROT = '0;
    ifc.S_AXIL_RREADY  = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_awready", ifc.S_AXIL_AWREADY, 1);
    check("rst_wready", ifc.S_AXIL_WREADY, 1);
    check("rst_arready", ifc.S_AXIL_ARREADY, 1);
    check("rst_bvalid", ifc.S_AXIL_BVALID, 0);
    check("rst_rvalid", ifc.S_AXIL_RVALID, 0);
    check("rst_rdata", ifc.S_AXIL_RDATA, 0);
    check("rst_bresp", ifc.S_AXIL_BRESP, 0);
    check("rst_rresp", ifc.S_AXIL_RRESP, 0);
    @(posedge clk); #1;

    wr(8'h08, 64'h0123456789ABCDEF, 8'hFF);
    rd(8'h08, "t1_rd");
    wr(8'h10, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
    rd(8'h10, "t2_rd");

    // AW leads W by three cycles
    ifc.S_AXIL_AWVALID = 1'b1; ifc.S_AXIL_AWADDR = 8'h18; ifc.S_AXIL_BREADY = 1'b1;
    @(negedge clk); check("t3_awready", ifc.S_AXIL_AWREADY, 1);
    @(posedge clk); #1; ifc.S_AXIL_AWVALID = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t3_awready_low", ifc.S_AXIL_AWREADY, 0);
      check("t3_no_bvalid", ifc.S_AXIL_BVALID, 0);
      @(posedge clk); #1;
    end
    ifc.S_AXIL_WVALID = 1'b1; ifc.S_AXIL_WDATA = 64'hAA; ifc.S_AXIL_WSTRB = 8'h01;
    @(negedge clk); check("t3_wready", ifc.S_AXIL_WREADY, 1);
    @(posedge clk); #1; ifc.S_AXIL_WVALID = 1'b0;
    @(negedge clk);
    check("t3_bvalid", ifc.S_AXIL_BVALID, 1);
    check("t3_awready_back", ifc.S_AXIL_AWREADY, 1);
    @(posedge clk); #1;
    @(negedge clk); check("t3_single_b", ifc.S_AXIL_BVALID, 0);
    @(posedge clk); #1;
    model_write(8'h18, 64'hAA, 8'h01);
    rd(8'h18, "t3_rd");

    bp_test();
    for (int i = 5; i < 8; i++) rd(8'(8*i), "t4_rd");

    // same-edge write and read of one register
    wr(8'h20, 64'h11, 8'hFF);
    ifc.S_AXIL_AWVALID = 1'b1; ifc.S_AXIL_AWADDR = 8'h20;
    ifc.S_AXIL_WVALID = 1'b1; ifc.S_AXIL_WDATA = 64'h55; ifc.S_AXIL_WSTRB = 8'hFF;
    ifc.S_AXIL_ARVALID = 1'b1; ifc.S_AXIL_ARADDR = 8'h20;
    ifc.S_AXIL_BREADY = 1'b1; ifc.S_AXIL_RREADY = 1'b1;
    @(negedge clk);
    check("t5_ready", {ifc.S_AXIL_AWREADY, ifc.S_AXIL_WREADY, ifc.S_AXIL_ARREADY}, 3'b111);
    @(posedge clk); #1;
    ifc.S_AXIL_AWVALID = 1'b0; ifc.S_AXIL_WVALID = 1'b0; ifc.S_AXIL_ARVALID = 1'b0;
    @(negedge clk);
    check("t5_bvalid", ifc.S_AXIL_BVALID, 1);
    check("t5_rvalid", ifc.S_AXIL_RVALID, 1);
    check("t5_rd_old", ifc.S_AXIL_RDATA, mem[4]);
    model_write(8'h20, 64'h55, 8'hFF);
    @(posedge clk); #1;
    rd(8'h20, "t5_rd_new");
    a9 = 9'h100;
    wr(a9[7:0], 64'hC0FFEE0012345678, 8'hFF);
    rd(8'h00, "t5_alias");
    wr(8'h05, 64'hDEADBEEF00000000, 8'hF0);
    rd(8'h00, "t5_lowbits");

    rnd_writes(40);
    for (int i = 0; i < 32; i++) rd(8'(8*i), "rnd_readback");
    rnd_reads(60);

    // reset while both responses are stalled
    ifc.S_AXIL_BREADY = 1'b0; ifc.S_AXIL_RREADY = 1'b0;
    ifc.S_AXIL_AWVALID = 1'b1; ifc.S_AXIL_AWADDR = 8'h08;
    ifc.S_AXIL_WVALID = 1'b1; ifc.S_AXIL_WDATA = 64'h1234; ifc.S_AXIL_WSTRB = 8'hFF;
    ifc.S_AXIL_ARVALID = 1'b1; ifc.S_AXIL_ARADDR = 8'h10;
    @(negedge clk);
    @(posedge clk); #1;
    ifc.S_AXIL_AWVALID = 1'b0; ifc.S_AXIL_WVALID = 1'b0; ifc.S_AXIL_ARVALID = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t6_pre_bvalid", ifc.S_AXIL_BVALID, 1);
    check("t6_pre_rvalid", ifc.S_AXIL_RVALID, 1);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("t6_bvalid", ifc.S_AXIL_BVALID, 0);
    check("t6_rvalid", ifc.S_AXIL_RVALID, 0);
    check("t6_rdata", ifc.S_AXIL_RDATA, 0);
    check("t6_ready", {ifc.S_AXIL_AWREADY, ifc.S_AXIL_WREADY, ifc.S_AXIL_ARREADY}, 3'b111);
    for (int i = 0; i < 32; i++) mem[i] = '0;
    @(posedge clk); #1;
    ifc.S_AXIL_BREADY = 1'b1; ifc.S_AXIL_RREADY = 1'b1;
    rd(8'h08, "t6_rd");
    rd(8'h20, "t6_rd_other");

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
